// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-word outputs of the UART receiver.
//   RX_IN      serial line, idle high
//   PRESCALE   CLK cycles per bit (even, 4..32)
//   PAR_EN     frame carries a parity bit
//   PAR_TYP    0 = even, 1 = odd parity
//   P_DATA     last error-free received word
//   DATA_VALID one-cycle strobe: P_DATA updated
//   PAR_ERR    one-cycle strobe: parity mismatch
//   STP_ERR    one-cycle strobe: stop bit sampled low
//   RX_BUSY    receiver is inside a frame
// master drives the line/config (line side), slave is the receiver.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  RX_BUSY;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver. Recovers start/data/parity/stop bits by a
// 3-sample majority vote around mid-bit and presents the word with a one-cycle strobe.
//   CLK  oversampling clock, rising edge
//   RST  asynchronous active-low reset
//   bus  uart_rx_if.slave: RX_IN/PRESCALE/PAR_EN/PAR_TYP in,
//        P_DATA/DATA_VALID/PAR_ERR/STP_ERR/RX_BUSY out (all registered)
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);

  localparam int unsigned PW = 6;
  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [PW-1:0]         p_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PW-1:0]         edge_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [1:0]            samp;
  logic                  bit_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err_q;

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  rx_busy;

  logic [PW-1:0] half_c;
  logic [PW-1:0] last_c;
  logic          at_last_c;
  logic          at_res_c;
  logic          at_abort_c;
  logic          maj_c;
  logic          bit_now_c;
  logic          exp_par_c;

  // Bit-position decode against the prescale latched at start detection
  assign half_c     = {1'b0, p_q[PW-1:1]};
  assign last_c     = p_q - PW'(1);
  assign at_last_c  = (edge_cnt == last_c);
  assign at_res_c   = (edge_cnt == half_c + PW'(1));
  // Glitch decision one edge after resolution; with P=4 that edge does not exist,
  // so the decision falls on the wrap instead.
  assign at_abort_c = (edge_cnt == half_c + PW'(2)) || (at_last_c && at_res_c);

  // Majority of the two stored samples and the third (current) one
  assign maj_c = (samp[0] & samp[1]) | (samp[0] & bus.RX_IN) | (samp[1] & bus.RX_IN);

  // Resolved bit value: live on the resolution edge, held afterwards
  assign bit_now_c = at_res_c ? maj_c : bit_q;

  assign exp_par_c = (^shreg) ^ par_typ_q;

  // Receiver FSM, counters, datapath and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      p_q        <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      bit_q      <= 1'b0;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state == IDLE) begin
        // The low-detect cycle is edge 0 of the start bit
        if (!bus.RX_IN) begin
          state     <= START;
          edge_cnt  <= PW'(1);
          bit_cnt   <= '0;
          p_q       <= bus.PRESCALE;
          par_en_q  <= bus.PAR_EN;
          par_typ_q <= bus.PAR_TYP;
          par_err_q <= 1'b0;
          rx_busy   <= 1'b1;
        end
      end else begin
        edge_cnt <= at_last_c ? '0 : edge_cnt + PW'(1);

        if (edge_cnt == half_c - PW'(1)) samp[0] <= bus.RX_IN;
        if (edge_cnt == half_c)          samp[1] <= bus.RX_IN;
        if (at_res_c)                    bit_q   <= maj_c;

        case (state)
          START: begin
            if (at_abort_c && bit_now_c) begin
              state    <= IDLE;
              edge_cnt <= '0;
              rx_busy  <= 1'b0;
            end else if (at_last_c) begin
              state <= DATA;
            end
          end

          DATA: begin
            if (at_last_c) begin
              // LSB arrives first, so shift right and insert at the MSB
              shreg <= DATA_WIDTH'({bit_now_c, shreg} >> 1);
              if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                bit_cnt <= '0;
                state   <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end

          PARITY: begin
            if (at_last_c) begin
              par_err_q <= (bit_now_c != exp_par_c);
              state     <= STOP;
            end
          end

          STOP: begin
            if (at_last_c) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (!bit_now_c || par_err_q) begin
                par_err <= par_err_q;
                stp_err <= ~bit_now_c;
              end else begin
                data_valid <= 1'b1;
                p_data     <= shreg;
              end
            end
          end

          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;
  assign bus.RX_BUSY    = rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. The driver serialises frames and pushes the
// expected strobe (kind, word, cycle) computed from the frame contents; a monitor pops
// and compares whenever a strobe appears.
module tb_uart_rx;

  localparam int unsigned DW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_pdata = '0;
  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: outcome of a frame from its bit contents
  task automatic push_expect(input logic [DW-1:0] data, input bit pen, input bit ptyp,
                             input bit pbit, input bit sbit, input int unsigned t_done);
    exp_t e;
    e.pe = pen && (((^data) ^ pbit) != ptyp);
    e.se = !sbit;
    e.dv = !e.pe && !e.se;
    if (e.dv) exp_pdata = data;
    e.data = exp_pdata;
    e.cyc  = t_done;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      bus.RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; spike >= 0 inverts data bit 'spike' for one cycle at mid-bit
  task automatic send_frame(input logic [DW-1:0] data, input int p, input bit pen,
                            input bit ptyp, input bit pbit, input bit sbit,
                            input int spike, output int unsigned t0);
    bit line[$];
    int n;
    line.push_back(1'b0);
    for (int i = 0; i < DW; i++) line.push_back(data[i]);
    if (pen) line.push_back(pbit);
    line.push_back(sbit);
    n = line.size();
    t0 = 0;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < p; k++) begin
        @(negedge CLK);
        if (k == 0) bus.RX_IN = line[b];
        if (b == 0 && k == 0) begin
          t0 = cyc;
          bus.PRESCALE = 6'(p);
          bus.PAR_EN   = pen;
          bus.PAR_TYP  = ptyp;
          push_expect(data, pen, ptyp, pbit, sbit, t0 + 32'(n * p));
        end
        // Configuration must be ignored once the frame has started
        if (b == 1 && k == 0) begin
          bus.PRESCALE = 6'(2 * $urandom_range(2, 16));
          bus.PAR_EN   = 1'($urandom_range(0, 1));
          bus.PAR_TYP  = 1'($urandom_range(0, 1));
        end
        if (spike >= 0 && b == spike + 1 && k == p / 2)     bus.RX_IN = ~line[b];
        if (spike >= 0 && b == spike + 1 && k == p / 2 + 1) bus.RX_IN = line[b];
      end
    end
  endtask

  // Monitor: compare each strobe against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got dv=%0b pe=%0b se=%0b, expected none (cycle %0d)",
                   bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, cyc);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("data_valid", bus.DATA_VALID, e.dv);
          chk("par_err", bus.PAR_ERR, e.pe);
          chk("stp_err", bus.STP_ERR, e.se);
          chk("p_data", bus.P_DATA, e.data);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_strobe: got no strobe, expected dv=%0b pe=%0b se=%0b at cycle %0d",
                 e.dv, e.pe, e.se, e.cyc);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge CLK);
    $display("FAIL timeout: got no end of stimulus, expected finish within 90000 cycles");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int          p;
    bit          pen, ptyp, pbit, sbit;
    logic [DW-1:0] d;
    bit          part[5];

    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    RST          = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_p_data", bus.P_DATA, 0);
    chk("rst_data_valid", bus.DATA_VALID, 0);
    chk("rst_par_err", bus.PAR_ERR, 0);
    chk("rst_stp_err", bus.STP_ERR, 0);
    chk("rst_rx_busy", bus.RX_BUSY, 0);
    RST = 1'b1;
    idle(2);

    // P=8, no parity, 0xA5; busy window edges
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    chk("busy_last_cycle", bus.RX_BUSY, 1);
    idle(1);
    chk("busy_after_frame", bus.RX_BUSY, 0);
    idle(3);

    // P=16, even parity: good then bad parity bit
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(2);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, t0);
    idle(2);

    // P=16 start glitch: 3 low cycles
    @(negedge CLK);
    bus.RX_IN    = 1'b0;
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b0;
    t0 = cyc;
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    bus.RX_IN = 1'b1;
    chk("glitch_busy_t1", bus.RX_BUSY, 1);
    while (cyc < t0 + 10) @(negedge CLK);
    chk("glitch_busy_t10", bus.RX_BUSY, 1);
    @(negedge CLK);
    chk("glitch_busy_t11", bus.RX_BUSY, 0);
    idle(2);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(2);

    // P=8 stop error, then mid-bit spikes rejected by the vote
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, t0);
    idle(2);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, t0);
    idle(1);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 5, t0);
    idle(2);

    // P=32 odd parity, back-to-back
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b1, -1, t0);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, 1'b1, -1, t0);
    idle(3);

    // Reset in the middle of 0x12 (start + 4 data bits)
    part = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        if (k == 0) bus.RX_IN = part[b];
      end
    end
    chk("busy_before_reset", bus.RX_BUSY, 1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_p_data", bus.P_DATA, 0);
    chk("midrst_data_valid", bus.DATA_VALID, 0);
    chk("midrst_par_err", bus.PAR_ERR, 0);
    chk("midrst_stp_err", bus.STP_ERR, 0);
    chk("midrst_rx_busy", bus.RX_BUSY, 0);
    exp_pdata = '0;
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(2);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(3);

    // Randomised frames
    for (int i = 0; i < 24; i++) begin
      p    = 2 * $urandom_range(2, 16);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      d    = DW'($urandom);
      pbit = (^d) ^ ptyp;
      if ($urandom_range(0, 4) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 5) != 0);
      send_frame(d, p, pen, ptyp, pbit, sbit,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW - 1)) : -1, t0);
      idle(int'($urandom_range(0, 3)));
    end

    idle(8);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that samples the UART line with an oversampling clock, recovers start/data/parity/stop bits by majority vote, and delivers the parallel byte with a one-cycle valid strobe. It is the receive-side counterpart of the transmit serializer/FSM path: same frame format (LSB first, optional even/odd parity, one stop bit), same single clock domain. It feeds the downstream register file / system controller.

## Interface
- DATA_WIDTH, default 8: data bits per frame.
- CLK  in  1  oversampling clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, idle high; already synchronised upstream.
- PRESCALE  in  6  oversampling ratio (CLK cycles per bit); legal values are even, 4..32.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  last correctly received word; updated only with DATA_VALID.
- DATA_VALID  out  1  one-cycle pulse: P_DATA holds a new error-free word.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch in the just-finished frame.
- STP_ERR  out  1  one-cycle pulse: stop bit sampled as 0.
- RX_BUSY  out  1  high while FSM is not IDLE.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters: edge_cnt (0..PRESCALE-1, position within a bit), bit_cnt (0..DATA_WIDTH-1).
- IDLE: when RX_IN = 0, that cycle is edge 0 of the start bit; latch PRESCALE, PAR_EN, PAR_TYP; go START with edge_cnt = 1. Mid-frame changes of these inputs are ignored.
- Sampling: RX_IN captured at edge_cnt = P/2-1, P/2, P/2+1 (P = latched prescale); bit value = majority of the three, resolved at edge P/2+1.
- edge_cnt wraps at P-1 to 0; state advance happens on the wrap.
- START: if majority = 1 (glitch), return to IDLE at edge P/2+2 with no output activity; else at wrap go DATA.
- DATA: shift majority bits LSB first into a shift register; after bit DATA_WIDTH-1 go PARITY if latched PAR_EN else STOP.
- PARITY: expected = XOR(data) for even, ~XOR(data) for odd; mismatch flagged internally.
- STOP: majority 0 flags stop error. At wrap of stop bit go IDLE and, in the following cycle, pulse:
  - DATA_VALID = 1 and P_DATA = shift register, iff no parity and no stop error;
  - PAR_ERR and/or STP_ERR otherwise (both may pulse together); P_DATA unchanged.
- Line held low (break): each frame ends with STP_ERR, IDLE immediately re-detects low and starts a new frame.
- Reset (any time, including mid-frame): FSM IDLE, counters 0, P_DATA = 0, DATA_VALID = PAR_ERR = STP_ERR = RX_BUSY = 0; partial frame discarded.

## Timing
- Frame length N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- Start detected at cycle t0 -> output pulse at cycle t0 + N*P, exactly one cycle wide.
- In that same cycle FSM is IDLE and may detect the next start bit: back-to-back frames with zero idle bits are received without loss.
- RX_BUSY high from t0+1 through t0+N*P-1 inclusive.
- Glitch rejection: RX_BUSY drops at t0 + P/2 + 3.
- Outputs are registered; no combinational path from RX_IN to any output.

## Test plan
- P=8, no parity, send 0xA5 -> DATA_VALID pulse at t0+80, P_DATA = 0xA5, PAR_ERR = STP_ERR = 0.
- P=16, even parity, send 0x3C with parity 0 -> DATA_VALID, P_DATA = 0x3C; resend with parity 1 -> PAR_ERR pulse at t0+176, no DATA_VALID, P_DATA stays 0x3C.
- P=16, RX_IN low for 3 cycles then high -> no pulses, RX_BUSY low again by t0+11; then valid 0x81 frame received correctly.
- P=8, send 0x55 with stop bit 0 -> STP_ERR pulse only, P_DATA unchanged; 1-cycle low spike at edge P/2 of a data bit -> data unaffected (majority).
- P=32, odd parity, two back-to-back frames 0x00 then 0xFF, no idle gap -> two DATA_VALID pulses exactly 352 cycles apart, values 0x00 and 0xFF.
- Assert RST mid-DATA of frame 0x12 -> all outputs 0 immediately; after release a new 0x34 frame yields P_DATA = 0x34, no stale error pulses.
